// File: rtl/md_issue_ctrl_if.sv
// Handshake and multiply-unit bundle between the execute stage, the issue
// controller and the HI/LO multiply/divide unit.
interface md_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             cancel;
  logic             req_ready;
  logic             stall;
  logic             md_busy;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [3:0]       MulOp;
  logic [1:0]       MTHILO;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;

  modport slave (
    input  req_valid, req_op, req_a, req_b, cancel, md_busy, md_hi, md_lo,
    output req_ready, stall, MulOp, MTHILO, SrcA, SrcB, rd_data, rd_valid
  );

  modport master (
    output req_valid, req_op, req_a, req_b, cancel, md_busy, md_hi, md_lo,
    input  req_ready, stall, MulOp, MTHILO, SrcA, SrcB, rd_data, rd_valid
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue/interlock controller in front of the HI/LO multiply/divide unit:
// turns accepted requests into one-cycle strobes and serves HI/LO reads.
module md_issue_ctrl #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] OP_IDLE = 4'b1111
) (
  input logic             clk,
  input logic             reset,
  md_issue_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] srcA_q, srcA_d;
  logic [WIDTH-1:0] srcB_q, srcB_d;
  logic [WIDTH-1:0] rdData_q, rdData_d;
  logic             rdValid_q, rdValid_d;

  logic ready;
  logic accept;
  logic isArith;
  logic isMove;
  logic isRead;

  assign ready   = (state_q == IDLE) && !bus.md_busy && !bus.cancel;
  assign accept  = bus.req_valid && ready;
  assign isArith = !bus.req_op[3];
  assign isMove  = (bus.req_op[3:1] == 3'b100);
  assign isRead  = (bus.req_op[3:1] == 3'b101);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_IDLE;
      srcA_q    <= '0;
      srcB_q    <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      srcA_q    <= srcA_d;
      srcB_q    <= srcB_d;
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
    end
  end

  // Moves to HI/LO finish in the issue cycle; arithmetic ops then wait on busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (isArith || isMove)) state_d = ISSUE;
      ISSUE:   state_d = (bus.cancel || op_q[3]) ? IDLE : WAIT;
      WAIT:    if (!bus.md_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    srcA_d    = srcA_q;
    srcB_d    = srcB_q;
    rdData_d  = rdData_q;
    rdValid_d = 1'b0;
    if (accept) begin
      if (isArith || isMove) begin
        op_d   = bus.req_op;
        srcA_d = bus.req_a;
      end
      if (isArith) srcB_d = bus.req_b;
      if (isRead) begin
        rdData_d  = bus.req_op[0] ? bus.md_hi : bus.md_lo;
        rdValid_d = 1'b1;
      end
    end
  end

  // Strobes exist only in ISSUE, so they can never outlive a single cycle.
  always_comb begin
    bus.MulOp  = OP_IDLE;
    bus.MTHILO = 2'b11;
    if (state_q == ISSUE && !bus.cancel) begin
      if (!op_q[3]) bus.MulOp  = op_q;
      else          bus.MTHILO = {1'b0, op_q[0]};
    end
  end

  always_comb begin
    bus.req_ready = ready;
    bus.stall     = bus.req_valid && !ready;
    bus.SrcA      = srcA_q;
    bus.SrcB      = srcB_q;
    bus.rd_data   = rdData_q;
    bus.rd_valid  = rdValid_q;
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: a behavioural multiply unit plus a transaction-level
// reference of the controller, checked every cycle, then directed and random traffic.
module tb_md_issue_ctrl;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_issue_ctrl_if #(.WIDTH(WIDTH)) bus();

  md_issue_ctrl #(.WIDTH(WIDTH), .OP_IDLE(4'b1111)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;
  bit checkEn = 0;
  int strobeCnt = 0;
  int mthiloCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiply/divide unit behaviour: result at the strobe, busy 4 (mult) or 9 (div) cycles after.
  function automatic logic [63:0] unitCompute(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb;
    logic [63:0] up, sp, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    sp = sa * sb;
    case (op)
      4'd0: return up;
      4'd1: return sp;
      4'd2: if (b == 0) return {a, 32'hFFFF_FFFF}; else return {a % b, a / b};
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: return acc + up;
      4'd5: return acc + sp;
      4'd6: return acc - up;
      4'd7: return acc - sp;
      default: return acc;
    endcase
  endfunction

  int unsigned busyCnt;
  logic [31:0] uHi, uLo;
  always @(posedge clk) begin
    if (reset) begin
      busyCnt <= 0;
      uHi     <= '0;
      uLo     <= '0;
    end else if (bus.MTHILO != 2'b11) begin
      if (bus.MTHILO[0]) uHi <= bus.SrcA;
      else               uLo <= bus.SrcA;
    end else if (busyCnt == 0 && !bus.MulOp[3]) begin
      {uHi, uLo} <= unitCompute(bus.MulOp, bus.SrcA, bus.SrcB, {uHi, uLo});
      busyCnt    <= (bus.MulOp[3:1] == 3'b001) ? 9 : 4;
    end else if (busyCnt != 0) begin
      busyCnt <= busyCnt - 1;
    end
  end
  assign bus.md_busy = (busyCnt != 0);
  assign bus.md_hi   = uHi;
  assign bus.md_lo   = uLo;

  // Reference: mPend holds the op whose issue cycle is current (-1 = none).
  int          mPend = -1;
  bit          mWait = 0;
  logic [31:0] mSrcA = '0, mSrcB = '0, mRd = '0;
  bit          mRdValid = 0;

  always @(posedge clk) begin
    int op;
    bit rdy;
    rdy = (mPend < 0) && !mWait && !bus.md_busy && !bus.cancel;
    op  = int'(bus.req_op);
    mRdValid = 0;
    if (reset) begin
      mPend = -1;
      mWait = 0;
      mSrcA = '0;
      mSrcB = '0;
      mRd   = '0;
    end else if (mPend >= 0) begin
      if (mPend < 8 && !bus.cancel) mWait = 1;
      mPend = -1;
    end else if (mWait) begin
      if (!bus.md_busy) mWait = 0;
    end else if (bus.req_valid && rdy) begin
      if (op < 10) begin
        mPend = op;
        mSrcA = bus.req_a;
        if (op < 8) mSrcB = bus.req_b;
      end else if (op < 12) begin
        mRd      = (op == 11) ? bus.md_hi : bus.md_lo;
        mRdValid = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit         expReady;
    logic [3:0] expMulOp;
    logic [1:0] expMthilo;
    if (bus.MulOp != 4'hF) strobeCnt++;
    if (bus.MTHILO != 2'b11) mthiloCnt++;
    if (checkEn) begin
      expReady  = (mPend < 0) && !mWait && !bus.md_busy && !bus.cancel;
      expMulOp  = (mPend >= 0 && mPend < 8 && !bus.cancel) ? mPend[3:0] : 4'hF;
      expMthilo = (mPend >= 8 && !bus.cancel) ? {1'b0, mPend[0]} : 2'b11;
      checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
      checkOutput("stall", 32'(bus.stall), 32'(bus.req_valid && !expReady));
      checkOutput("MulOp", 32'(bus.MulOp), 32'(expMulOp));
      checkOutput("MTHILO", 32'(bus.MTHILO), 32'(expMthilo));
      checkOutput("SrcA", bus.SrcA, mSrcA);
      checkOutput("SrcB", bus.SrcB, mSrcB);
      checkOutput("rd_valid", 32'(bus.rd_valid), 32'(mRdValid));
      checkOutput("rd_data", bus.rd_data, mRd);
    end
  end

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic c);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.cancel    = c;
  endtask

  // Holds a request until accepted; returns with inputs idle, 1 time unit after the accept edge.
  task automatic sendReq(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
    bit got;
    got    = 0;
    stalls = 0;
    applyStimulus(1'b1, op, a, b, 1'b0);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 4'hC, '0, '0, 1'b0);
    if (!got) begin
      vectors++;
      errors++;
      $display("[TB] FAIL handshake timeout: op %h never accepted, ready stayed 0", op);
    end
  endtask

  task automatic readCheck(input logic [3:0] op, input logic [31:0] exp, input int expStalls);
    int st;
    sendReq(op, '0, '0, st);
    checkOutput("read stall cycles", 32'(st), 32'(expStalls));
    @(negedge clk);
    checkOutput("read rd_valid pulse", 32'(bus.rd_valid), 32'd1);
    checkOutput("read rd_data", bus.rd_data, exp);
    @(negedge clk);
    checkOutput("read rd_valid drop", 32'(bus.rd_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " MulOp"}, 32'(bus.MulOp), 32'hF);
    checkOutput({tag, " MTHILO"}, 32'(bus.MTHILO), 32'd3);
    checkOutput({tag, " rd_valid"}, 32'(bus.rd_valid), 32'd0);
    checkOutput({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st, s0;
    reset = 1'b1;
    applyStimulus(1'b0, 4'hC, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    checkEn = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("reset SrcA", bus.SrcA, 32'd0);
    checkOutput("reset rd_data", bus.rd_data, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] mult 0xFFFFFFFF * 2");
    s0 = strobeCnt;
    sendReq(4'd1, 32'hFFFF_FFFF, 32'd2, st);
    readCheck(4'd11, 32'hFFFF_FFFF, 6);
    checkOutput("mult strobe count", 32'(strobeCnt - s0), 32'd1);
    readCheck(4'd10, 32'hFFFF_FFFE, 0);

    $display("[TB] divu 100 / 7");
    sendReq(4'd2, 32'd100, 32'd7, st);
    readCheck(4'd10, 32'd14, 11);
    readCheck(4'd11, 32'd2, 0);

    $display("[TB] mthi then mfhi");
    s0 = mthiloCnt;
    sendReq(4'd9, 32'h1234_5678, 32'd0, st);
    readCheck(4'd11, 32'h1234_5678, 1);
    checkOutput("mthi strobe count", 32'(mthiloCnt - s0), 32'd1);

    $display("[TB] mult cancelled in issue cycle");
    s0 = strobeCnt;
    sendReq(4'd1, 32'd5, 32'd6, st);
    applyStimulus(1'b0, 4'hC, '0, '0, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 4'hC, '0, '0, 1'b0);
    checkOutput("cancel strobe count", 32'(strobeCnt - s0), 32'd0);
    readCheck(4'd11, 32'h1234_5678, 0);
    readCheck(4'd10, 32'd14, 0);

    $display("[TB] reset during div wait");
    sendReq(4'd3, 32'hFFFF_FF9C, 32'd7, st);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset in wait");
    @(posedge clk);
    #1;

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                    $urandom_range(0, 9) == 0);
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 4'hC, '0, '0, 1'b0);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    checkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
